pipeline_ctrl: RTL and testbench



---
 rtl/cpu_pkg.sv | 34 +++
 rtl/hazard_detect.sv | 17 +
 rtl/pipeline_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register address width, pipeline controller states
// and the bundle of pipeline control strobes.
package cpu_pkg;

    localparam int unsigned REG_ADDR_W      = 5;
    localparam int unsigned CNT_W_DEF       = 32;
    localparam int unsigned MEM_TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        MEMWAIT = 2'd2
    } pctrl_state_t;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_we;
    } pctrl_ctl_t;

    // Free-running pipeline: every register advances, optional IF/ID flush.
    function automatic pctrl_ctl_t ctl_advance(input logic flush);
        pctrl_ctl_t c;
        c.pc_we       = 1'b1;
        c.ifid_we     = 1'b1;
        c.ifid_flush  = flush;
        c.idex_bubble = 1'b0;
        c.pipe_we     = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources of ID.
module hazard_detect
    import cpu_pkg::*;
(
    input  logic                  ex_memread_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    output logic                  load_use_o
);

    // x0 is never a real producer, so a load into it cannot create a hazard.
    assign load_use_o = ex_memread_i
                     && (ex_rd_i != '0)
                     && ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing / hazard controller: run gating, load-use stall, branch flush,
// memory freeze with timeout. Event counters exist only with PIPELINE_CTRL_PERF_CNT_EN.
module pipeline_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  ex_memread_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  id_branch_taken_i,
    input  logic                  mem_req_i,
    input  logic                  mem_ack_i,
    output logic                  pc_we_o,
    output logic                  ifid_we_o,
    output logic                  ifid_flush_o,
    output logic                  idex_bubble_o,
    output logic                  pipe_we_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o,
    output logic                  err_o
);

    localparam int unsigned TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    pctrl_state_t     state_q;
    pctrl_state_t     state_d;
    pctrl_ctl_t       ctl;
    logic             load_use;
    logic             freeze;
    logic             stall_ev;
    logic             flush_ev;
    logic [TMO_W-1:0] frz_cnt_q;
    logic [TMO_W-1:0] frz_cnt_d;
    logic             tmo_hit;

    hazard_detect u_hazard_detect (
        .ex_memread_i (ex_memread_i),
        .ex_rd_i      (ex_rd_i),
        .id_rs1_i     (id_rs1_i),
        .id_rs2_i     (id_rs2_i),
        .load_use_o   (load_use)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and control strobes; dropping start_i halts everything in place.
    always_comb begin
        state_d  = state_q;
        ctl      = '0;
        freeze   = 1'b0;
        stall_ev = 1'b0;
        flush_ev = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                end
            end
            RUN, MEMWAIT: begin
                if (!start_i) begin
                    state_d = IDLE;
                end else begin
                    if (state_q == RUN) begin
                        freeze = mem_req_i && !mem_ack_i;
                    end else begin
                        freeze = !mem_ack_i;
                    end
                    state_d = freeze ? MEMWAIT : RUN;
                    if (freeze) begin
                        ctl = '0;
                    end else if (load_use) begin
                        // Branch operand is stale during the stall, so no flush yet.
                        ctl.idex_bubble = 1'b1;
                        ctl.pipe_we     = 1'b1;
                        stall_ev        = 1'b1;
                    end else if (id_branch_taken_i) begin
                        ctl      = ctl_advance(1'b1);
                        flush_ev = 1'b1;
                    end else begin
                        ctl = ctl_advance(1'b0);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pc_we_o       = ctl.pc_we;
    assign ifid_we_o     = ctl.ifid_we;
    assign ifid_flush_o  = ctl.ifid_flush;
    assign idex_bubble_o = ctl.idex_bubble;
    assign pipe_we_o     = ctl.pipe_we;

    // Freeze-cycle count: the RUN cycle that raises the request is freeze cycle 1.
    always_comb begin
        frz_cnt_d = frz_cnt_q;
        tmo_hit   = 1'b0;
        if (state_q == RUN) begin
            frz_cnt_d = TMO_W'(1);
        end else if (frz_cnt_q != TMO_W'(MEM_TIMEOUT)) begin
            frz_cnt_d = frz_cnt_q + TMO_W'(1);
        end
        if (MEM_TIMEOUT != 0) begin
            tmo_hit = (frz_cnt_d == TMO_W'(MEM_TIMEOUT));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frz_cnt_q <= '0;
            err_o     <= 1'b0;
        end else if (freeze) begin
            frz_cnt_q <= frz_cnt_d;
            if (tmo_hit) begin
                err_o <= 1'b1;
            end
        end
    end

`ifdef PIPELINE_CTRL_PERF_CNT_EN
    // Stall / flush event counters, wrapping naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_ev) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
            if (flush_ev) begin
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end
        end
    end
`else
    logic unused_ev;
    assign unused_ev   = stall_ev ^ flush_ev;
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios then random traffic, all checked
// against a behavioural model of run/freeze/stall/flush rules.
module tb_pipeline_ctrl;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned TMO   = 4;
`ifdef PIPELINE_CTRL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             start;
    logic [4:0]       rs1, rs2, rd;
    logic             memread, br, req, ack;
    logic             pc_we, ifid_we, ifid_flush, idex_bubble, pipe_we, err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit m_running;
    bit m_mem_pending;
    int m_frz;
    bit m_err;
    int m_stalls;
    int m_flushes;

    pipeline_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .start_i           (start),
        .id_rs1_i          (rs1),
        .id_rs2_i          (rs2),
        .ex_memread_i      (memread),
        .ex_rd_i           (rd),
        .id_branch_taken_i (br),
        .mem_req_i         (req),
        .mem_ack_i         (ack),
        .pc_we_o           (pc_we),
        .ifid_we_o         (ifid_we),
        .ifid_flush_o      (ifid_flush),
        .idex_bubble_o     (idex_bubble),
        .pipe_we_o         (pipe_we),
        .stall_cnt_o       (stall_cnt),
        .flush_cnt_o       (flush_cnt),
        .err_o             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare against the model, then advance the model.
    task automatic step(input bit r, input bit st, input logic [4:0] a1, input logic [4:0] a2,
                        input bit mr, input logic [4:0] d, input bit b, input bit rq, input bit ak);
        bit active, frz, lu;
        bit e_pc, e_ifid, e_fl, e_bub, e_pipe;
        @(negedge clk);
        rst = r; start = st; rs1 = a1; rs2 = a2; memread = mr; rd = d; br = b; req = rq; ack = ak;
        #1;
        active = m_running && st;
        frz    = active && (m_mem_pending ? !ak : (rq && !ak));
        lu     = mr && (d != 5'd0) && (d == a1 || d == a2);
        {e_pc, e_ifid, e_fl, e_bub, e_pipe} = 5'b0;
        if (active && !frz) begin
            if (lu) begin
                e_bub = 1'b1; e_pipe = 1'b1;
            end else begin
                e_pc = 1'b1; e_ifid = 1'b1; e_pipe = 1'b1; e_fl = b;
            end
        end
        check("pc_we", 32'(pc_we), 32'(e_pc));
        check("ifid_we", 32'(ifid_we), 32'(e_ifid));
        check("ifid_flush", 32'(ifid_flush), 32'(e_fl));
        check("idex_bubble", 32'(idex_bubble), 32'(e_bub));
        check("pipe_we", 32'(pipe_we), 32'(e_pipe));
        check("stall_cnt", 32'(stall_cnt), PERF ? 32'(m_stalls % (1 << CNT_W)) : 32'd0);
        check("flush_cnt", 32'(flush_cnt), PERF ? 32'(m_flushes % (1 << CNT_W)) : 32'd0);
        check("err", 32'(err), 32'(m_err));
        @(posedge clk);
        if (r) begin
            m_running = 0; m_mem_pending = 0; m_frz = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
        end else if (!m_running) begin
            m_running = st;
        end else if (!st) begin
            m_running = 0; m_mem_pending = 0;
        end else begin
            if (frz) begin
                m_frz = m_mem_pending ? m_frz + 1 : 1;
                if (TMO != 0 && m_frz >= TMO) m_err = 1;
            end else if (lu) begin
                m_stalls++;
            end else if (b) begin
                m_flushes++;
            end
            m_mem_pending = frz;
        end
    endtask

    task automatic idle_run(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; start = 0; rs1 = 0; rs2 = 0; rd = 0; memread = 0; br = 0; req = 0; ack = 0;
        // Reset with start already high: start ignored in the reset cycle.
        step(1, 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
        step(0, 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
        idle_run(2);
        check("run_pc_we", 32'(pc_we), 32'd1);
        // lw x1 in EX, add x2,x1,x3 in ID; bubble reaches EX next cycle.
        step(0, 1, 5'd1, 5'd3, 1, 5'd1, 0, 0, 0);
        step(0, 1, 5'd1, 5'd3, 0, 5'd0, 0, 0, 0);
        // Load into x0 never stalls.
        step(0, 1, 5'd0, 5'd3, 1, 5'd0, 0, 0, 0);
        // Taken branch, no hazard.
        step(0, 1, 5'd4, 5'd5, 0, 5'd0, 1, 0, 0);
        // Load-use with branch: stall first, flush next cycle.
        step(0, 1, 5'd6, 5'd7, 1, 5'd7, 1, 0, 0);
        step(0, 1, 5'd6, 5'd7, 0, 5'd0, 1, 0, 0);
        idle_run(1);
        // Memory access acked three cycles after request.
        for (int i = 0; i < 3; i++) step(0, 1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0);
        step(0, 1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1);
        idle_run(1);
        // No ack: timeout raises sticky err while still frozen.
        for (int i = 0; i < 6; i++) step(0, 1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0);
        check("err_sticky", 32'(err), 32'd1);
        step(0, 1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1);
        idle_run(1);
        check("err_after_ack", 32'(err), 32'd1);
        // Reset in the middle of a freeze.
        for (int i = 0; i < 2; i++) step(0, 1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0);
        step(1, 1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0);
        step(0, 1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0);
        check("err_cleared", 32'(err), 32'd0);
        idle_run(2);
        // Random traffic, including start drops and rare resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 1),
                 ($urandom_range(0, 99) < 93),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 99) < 35),
                 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 40));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
